// File: rtl/frame_seq_pkg.sv
// Shared types and constants for the frame sequencing controller.
package frame_seq_pkg;

    localparam int PIX_W  = 20;
    localparam int FCNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BEGIN,
        S_WAIT_SRC,
        S_WAIT_OUT,
        S_NEXT,
        S_DONE,
        S_ERR
    } seq_state_e;

    function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/seq_edge_det.sv
// One-cycle rising-edge detect; the pulse is combinational in the cycle the input first reads high.
module seq_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise
);

    logic sig_q, sig_d;

    always_comb sig_d = sig_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= 1'b0;
        else        sig_q <= sig_d;
    end

    assign rise = sig_in & ~sig_q;

endmodule

// File: rtl/frame_seq_ctrl.sv
// Sequences N frames through the bmp source / filter chain and checks per-frame pixel counts.
// Build option FRAME_SEQ_TIMEOUT_EN adds a per-frame watchdog with the ERR exit.
//
//   state      | meaning
//   S_IDLE     | waiting for start
//   S_BEGIN    | src_begin held high for BEGIN_LEN cycles
//   S_WAIT_SRC | waiting for the source end-of-frame
//   S_WAIT_OUT | waiting for the filter output to finish the frame
//   S_NEXT     | bump frame_cnt, decide next frame or done
//   S_DONE     | one-cycle seq_done
//   S_ERR      | watchdog expired, back to idle
module frame_seq_ctrl
    import frame_seq_pkg::*;
#(
    parameter int H_DISP      = 800,
    parameter int V_DISP      = 600,
    parameter int BEGIN_LEN   = 5,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [FCNT_W-1:0] frame_num,
    output logic              src_begin,
    input  logic              src_done,
    input  logic              post_img_vsync,
    input  logic              post_img_valid,
    output logic              busy,
    output logic              seq_done,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              pix_err,
    output logic              tmo_err
);

    localparam logic [PIX_W-1:0] FRAME_PIX = PIX_W'(H_DISP * V_DISP);
    localparam logic [3:0]       BEG_LOAD  = 4'(BEGIN_LEN - 1);

    seq_state_e        state_q, state_d;
    logic [3:0]        beg_cnt_q, beg_cnt_d;
    logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [FCNT_W-1:0] frame_num_q, frame_num_d;
    logic              pix_err_q, pix_err_d;
    logic              vsync_seen_q, vsync_seen_d;
    logic              vsync_rise, pix_full, pix_short, in_frame, frame_end;
    logic              enter_begin, wd_exp;

    seq_edge_det u_vsync_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (post_img_vsync),
        .rise   (vsync_rise)
    );

    assign in_frame    = (state_q == S_BEGIN) || (state_q == S_WAIT_SRC) || (state_q == S_WAIT_OUT);
    assign pix_full    = (pix_cnt_q == FRAME_PIX);
    assign pix_short   = vsync_rise && (pix_cnt_q != '0) && (pix_cnt_q < FRAME_PIX);
    // a short frame seen before src_done is remembered so WAIT_SRC can skip WAIT_OUT
    assign frame_end   = pix_full || pix_short || vsync_seen_q;
    assign enter_begin = (state_d == S_BEGIN) && (state_q != S_BEGIN);

    always_comb begin
        state_d      = state_q;
        beg_cnt_d    = beg_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        frame_num_d  = frame_num_q;
        pix_err_d    = pix_err_q;
        vsync_seen_d = vsync_seen_q;

        if (in_frame && post_img_valid && !pix_full) pix_cnt_d = pix_cnt_q + 1'b1;
        if (in_frame && pix_short) pix_err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_BEGIN;
                    frame_num_d = (frame_num == '0) ? FCNT_W'(1) : frame_num;
                    frame_cnt_d = '0;
                    pix_err_d   = 1'b0;
                end
            end
            S_BEGIN: begin
                if (pix_short) vsync_seen_d = 1'b1;
                if (beg_cnt_q == '0) state_d = S_WAIT_SRC;
                else                 beg_cnt_d = beg_cnt_q - 1'b1;
            end
            S_WAIT_SRC: begin
                if (pix_short) vsync_seen_d = 1'b1;
                if (src_done) state_d = frame_end ? S_NEXT : S_WAIT_OUT;
            end
            S_WAIT_OUT: begin
                if (frame_end) state_d = S_NEXT;
            end
            S_NEXT: begin
                frame_cnt_d = sat_inc(frame_cnt_q);
                if (({1'b0, frame_cnt_q} + 9'd1) >= {1'b0, frame_num_q}) state_d = S_DONE;
                else                                                     state_d = S_BEGIN;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (wd_exp) state_d = S_ERR;

        if ((state_d == S_BEGIN) && (state_q != S_BEGIN)) begin
            beg_cnt_d    = BEG_LOAD;
            pix_cnt_d    = '0;
            vsync_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            beg_cnt_q    <= '0;
            pix_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            frame_num_q  <= '0;
            pix_err_q    <= 1'b0;
            vsync_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beg_cnt_q    <= beg_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_num_q  <= frame_num_d;
            pix_err_q    <= pix_err_d;
            vsync_seen_q <= vsync_seen_d;
        end
    end

`ifdef FRAME_SEQ_TIMEOUT_EN
    localparam int             WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            tmo_err_q, tmo_err_d;
    logic            wd_run;

    assign wd_run = (state_q == S_WAIT_SRC) || (state_q == S_WAIT_OUT);
    // down-counter: terminal count 0 is reached in the TIMEOUT_CYC-th waiting cycle
    assign wd_exp = wd_run && (wd_cnt_q == '0);

    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        tmo_err_d = tmo_err_q;
        if (enter_begin)                   wd_cnt_d = WD_LOAD;
        else if (wd_run && !wd_exp)        wd_cnt_d = wd_cnt_q - 1'b1;
        if ((state_q == S_IDLE) && start)  tmo_err_d = 1'b0;
        if (wd_exp)                        tmo_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q  <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign tmo_err = tmo_err_q;
`else
    logic unused_enter_begin;
    assign unused_enter_begin = enter_begin;
    assign wd_exp  = 1'b0;
    // always 0: no watchdog in this build
    assign tmo_err = (TIMEOUT_CYC < 0);
`endif

    assign src_begin = (state_q == S_BEGIN);
    assign busy      = (state_q != S_IDLE);
    assign seq_done  = (state_q == S_DONE);
    assign frame_cnt = frame_cnt_q;
    assign pix_err   = pix_err_q;

endmodule
